// File: rtl/audio_sched_pkg.sv
// Shared types and defaults for the audio sample scheduler: FSM state
// encoding, width/timeout defaults and filter channel selects.
package audio_sched_pkg;

  localparam int DW_DEF      = 24;
  localparam int TIMEOUT_DEF = 255;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    FILT_L,
    FILT_R,
    WAIT_WR,
    WRITE
  } state_e;

endpackage

// File: rtl/audio_sample_scheduler_filt_watchdog.sv
// Filter-wait watchdog: start loads a TIMEOUT-cycle down-counter, ack disarms it,
// expired flags terminal count while still armed.
module filt_watchdog
  import audio_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (start_i) begin
      cnt_q   <= LOAD;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (ack_i || (cnt_q == '0)) armed_q <= 1'b0;
      else                        cnt_q   <= cnt_q - CW'(1);
    end
  end

  assign expired_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/audio_sample_scheduler.sv
// Codec sample-pair scheduler: pop a pair, run each channel through the shared
// FIR (with timeout fallback to raw), push to the DAC. Optional BYPASS_EN adds
// a bypass input that skips the filter.
//
//   state    | meaning
//   IDLE     | wait for read_ready, latch raw pair
//   CAPTURE  | read pulse to codec
//   FILT_L   | left channel in filter
//   FILT_R   | right channel in filter
//   WAIT_WR  | wait for DAC FIFO space
//   WRITE    | write pulse, count sample
module audio_sample_scheduler
  import audio_sched_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          read_ready,
  input  logic [DW-1:0] readdata_left,
  input  logic [DW-1:0] readdata_right,
  output logic          read,
  input  logic          write_ready,
  output logic          write,
  output logic [DW-1:0] writedata_left,
  output logic [DW-1:0] writedata_right,
  output logic          filt_req,
  output logic          filt_ch,
  output logic [DW-1:0] filt_din,
  input  logic          filt_ack,
  input  logic [DW-1:0] filt_dout,
`ifdef BYPASS_EN
  input  logic          bypass,
`endif
  output logic          busy,
  output logic [15:0]   sample_cnt,
  output logic          timeout_err
);

  state_e        state_q, state_d;
  logic [DW-1:0] raw_l_q, raw_l_d, raw_r_q, raw_r_d;
  logic [DW-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic [DW-1:0] wd_l_q, wd_l_d, wd_r_q, wd_r_d;
  logic [DW-1:0] filt_din_q, filt_din_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          read_q, read_d, write_q, write_d;
  logic          req_q, req_d, ch_q, ch_d, busy_q, busy_d;
  logic          wd_start, wd_expired;

  filt_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i     (CLOCK_50),
    .rst_ni    (resetn),
    .start_i   (wd_start),
    .ack_i     (filt_ack),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    raw_l_d  = raw_l_q;
    raw_r_d  = raw_r_q;
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    wd_l_d   = wd_l_q;
    wd_r_d   = wd_r_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wd_start = 1'b0;

    case (state_q)
      IDLE: if (read_ready) begin
        raw_l_d = readdata_left;
        raw_r_d = readdata_right;
        state_d = CAPTURE;
      end
      CAPTURE: begin
`ifdef BYPASS_EN
        if (bypass) begin
          out_l_d = raw_l_q;
          out_r_d = raw_r_q;
          state_d = WAIT_WR;
        end else
`endif
        begin
          wd_start = 1'b1;
          state_d  = FILT_L;
        end
      end
      // ack wins over a simultaneous expiry: a late-but-valid result is kept
      FILT_L: if (filt_ack || wd_expired) begin
        out_l_d  = filt_ack ? filt_dout : raw_l_q;
        err_d    = err_q | ~filt_ack;
        wd_start = 1'b1;
        state_d  = FILT_R;
      end
      FILT_R: if (filt_ack || wd_expired) begin
        out_r_d = filt_ack ? filt_dout : raw_r_q;
        err_d   = err_q | ~filt_ack;
        state_d = WAIT_WR;
      end
      WAIT_WR: if (write_ready) begin
        wd_l_d  = out_l_q;
        wd_r_d  = out_r_q;
        cnt_d   = cnt_q + 16'd1;
        state_d = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Moore outputs are registered from the next state
    read_d     = (state_d == CAPTURE);
    write_d    = (state_d == WRITE);
    req_d      = (state_d == FILT_L) || (state_d == FILT_R);
    ch_d       = (state_d == FILT_R) ? CH_RIGHT : CH_LEFT;
    busy_d     = (state_d != IDLE);
    filt_din_d = filt_din_q;
    if (state_d == FILT_L) filt_din_d = raw_l_d;
    if (state_d == FILT_R) filt_din_d = raw_r_d;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      raw_l_q    <= '0;
      raw_r_q    <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      wd_l_q     <= '0;
      wd_r_q     <= '0;
      filt_din_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      req_q      <= 1'b0;
      ch_q       <= CH_LEFT;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      raw_l_q    <= raw_l_d;
      raw_r_q    <= raw_r_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      wd_l_q     <= wd_l_d;
      wd_r_q     <= wd_r_d;
      filt_din_q <= filt_din_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      read_q     <= read_d;
      write_q    <= write_d;
      req_q      <= req_d;
      ch_q       <= ch_d;
      busy_q     <= busy_d;
    end
  end

  assign read            = read_q;
  assign write           = write_q;
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;
  assign filt_req        = req_q;
  assign filt_ch         = ch_q;
  assign filt_din        = filt_din_q;
  assign busy            = busy_q;
  assign sample_cnt      = cnt_q;
  assign timeout_err     = err_q;

endmodule
